// File: rtl/var_shift_pkg.sv
// Shared types and width helpers for the variable shift engine.
package var_shift_pkg;

  typedef enum logic [1:0] {
    SH_LOG  = 2'd0,
    SH_ARI  = 2'd1,
    SH_ROT  = 2'd2,
    SH_FILL = 2'd3
  } shift_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shift-amount width: covers 0..2*WIDTH-1.
  function automatic int unsigned shw_of(input int unsigned width);
    return $clog2(width) + 1;
  endfunction

  // Per-cycle step width: covers 0..STEP.
  function automatic int unsigned stw_of(input int unsigned step);
    return $clog2(step) + 1;
  endfunction

endpackage

// File: rtl/shift_step.sv
// One bounded shift step on the {fill, work} pair, all modes, both directions.
module shift_step
  import var_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SW    = 4
) (
  input  logic [WIDTH-1:0] work_i,
  input  logic [WIDTH-1:0] fill_i,
  input  logic [SW-1:0]    amt_i,
  input  logic             dir_i,
  input  shift_mode_e      mode_i,
  input  logic             sign_i,
  output logic [WIDTH-1:0] work_o,
  output logic [WIDTH-1:0] fill_o
);

  logic [WIDTH-1:0]   ext;
  logic [2*WIDTH-1:0] pair;
  logic [2*WIDTH-1:0] moved;

  // Extension word supplies the bits shifted into work; fill mode also consumes it.
  always_comb begin
    ext    = '0;
    pair   = '0;
    moved  = '0;
    work_o = work_i;
    fill_o = fill_i;
    case (mode_i)
      SH_ARI:  ext = dir_i ? '0 : {WIDTH{sign_i}};
      SH_ROT:  ext = work_i;
      SH_FILL: ext = fill_i;
      default: ext = '0;
    endcase
    if (dir_i) begin
      pair   = {work_i, ext};
      moved  = pair << amt_i;
      work_o = moved[2*WIDTH-1:WIDTH];
      if (mode_i == SH_FILL) fill_o = moved[WIDTH-1:0];
    end else begin
      pair   = {ext, work_i};
      moved  = pair >> amt_i;
      work_o = moved[WIDTH-1:0];
      if (mode_i == SH_FILL) fill_o = moved[2*WIDTH-1:WIDTH];
    end
  end

endmodule

// File: rtl/var_shift_engine.sv
// Multi-cycle variable shift engine: accepts a request, shifts up to STEP bits
// per enabled cycle, then presents the result until the consumer takes it.
module var_shift_engine
  import var_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned STEP  = 8,
  parameter int unsigned SHW   = shw_of(WIDTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic [SHW-1:0]   shift,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] fill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] q,
  output logic             busy
);

  localparam int unsigned LW = $clog2(WIDTH);
  localparam int unsigned SW = stw_of(STEP);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q,  work_d;
  logic [WIDTH-1:0] fill_q,  fill_d;
  logic [SHW-1:0]   rem_q,   rem_d;
  logic             dir_q,   dir_d;
  shift_mode_e      mode_q,  mode_d;
  logic             sign_q,  sign_d;
  logic [WIDTH-1:0] q_q,     q_d;

  logic [SW-1:0]    step_amt;
  logic [WIDTH-1:0] work_step;
  logic [WIDTH-1:0] fill_step;

  // Bits to move this cycle: the smaller of what remains and STEP.
  always_comb begin
    step_amt = (rem_q > SHW'(STEP)) ? SW'(STEP) : SW'(rem_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .SW    (SW)
  ) u_step (
    .work_i (work_q),
    .fill_i (fill_q),
    .amt_i  (step_amt),
    .dir_i  (dir_q),
    .mode_i (mode_q),
    .sign_i (sign_q),
    .work_o (work_step),
    .fill_o (fill_step)
  );

  // Next-state and working-register update.
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    fill_d  = fill_q;
    rem_d   = rem_q;
    dir_d   = dir_q;
    mode_d  = mode_q;
    sign_d  = sign_q;
    q_d     = q_q;
    case (state_q)
      IDLE: begin
        if (in_valid && en) begin
          work_d  = data;
          fill_d  = fill;
          dir_d   = dir;
          mode_d  = shift_mode_e'(mode);
          sign_d  = data[WIDTH-1];
          // Rotation wraps; every other mode saturates at a full word.
          if (shift_mode_e'(mode) == SH_ROT) rem_d = SHW'(shift[LW-1:0]);
          else rem_d = (shift > SHW'(WIDTH)) ? SHW'(WIDTH) : shift;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (en) begin
          work_d = work_step;
          fill_d = fill_step;
          rem_d  = rem_q - SHW'(step_amt);
          if (rem_q == SHW'(step_amt)) begin
            q_d     = work_step;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight request.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= IDLE;
      work_q  <= '0;
      fill_q  <= '0;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      mode_q  <= SH_LOG;
      sign_q  <= 1'b0;
      q_q     <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      fill_q  <= fill_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      mode_q  <= mode_d;
      sign_q  <= sign_d;
      q_q     <= q_d;
    end
  end

  assign in_ready  = (state_q == IDLE) && en;
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign q         = q_q;

endmodule

// File: tb/tb_var_shift_engine.sv
// Bench for var_shift_engine: directed cases plus random traffic against a
// transaction-level reference that computes whole shifts and latencies directly.
module tb_var_shift_engine;

  localparam int W = 32;

  logic        clk = 1'b0;
  logic        clr;
  logic        en;
  logic        in_valid;
  logic        in_ready;
  logic        dir_i;
  logic [1:0]  mode_i;
  logic [5:0]  shift_i;
  logic [31:0] data_i;
  logic [31:0] fill_i;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] q;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  var_shift_engine #(.WIDTH(32), .STEP(8)) dut (
    .clk       (clk),
    .clr       (clr),
    .en        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dir       (dir_i),
    .mode      (mode_i),
    .shift     (shift_i),
    .data      (data_i),
    .fill      (fill_i),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q         (q),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Whole-operation result computed straight from the shift definitions.
  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [31:0] f,
                                            input int n, input bit dr, input int md);
    logic [63:0] p;
    int m;
    int r;
    m = (n > W) ? W : n;
    r = n % W;
    case (md)
      0: return dr ? (d << m) : (d >> m);
      1: return dr ? (d << m) : 32'($signed(d) >>> m);
      2: begin
        if (r == 0) return d;
        return dr ? ((d << r) | (d >> (W - r))) : ((d >> r) | (d << (W - r)));
      end
      default: begin
        if (dr) begin p = {d, f} << m; return p[63:32]; end
        p = {f, d} >> m;
        return p[31:0];
      end
    endcase
  endfunction

  // Number of enabled SHIFT cycles the request needs.
  function automatic int ref_k(input int n, input int md);
    int rem;
    rem = (md == 2) ? (n % W) : ((n > W) ? W : n);
    return (rem == 0) ? 1 : (rem + 7) / 8;
  endfunction

  // Transaction-level model: idle / working for k enabled cycles / holding result.
  logic        m_busy;
  logic        m_valid;
  int          m_left;
  logic [31:0] m_q;
  logic [31:0] m_res;

  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      m_busy  <= 1'b0;
      m_valid <= 1'b0;
      m_left  <= 0;
      m_q     <= '0;
      m_res   <= '0;
    end else if (m_valid) begin
      if (out_ready) begin
        m_valid <= 1'b0;
        m_busy  <= 1'b0;
      end
    end else if (m_busy) begin
      if (en) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_valid <= 1'b1;
          m_q     <= m_res;
        end
      end
    end else if (en && in_valid) begin
      m_busy <= 1'b1;
      m_left <= ref_k(int'(shift_i), int'(mode_i));
      m_res  <= ref_shift(data_i, fill_i, int'(shift_i), dir_i, int'(mode_i));
    end
  end

  // Cycle-by-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (clr) begin
      chk("cyc_out_valid", 32'(out_valid), 32'(m_valid));
      chk("cyc_busy", 32'(busy), 32'(m_busy));
      chk("cyc_in_ready", 32'(in_ready), 32'(!m_busy && en));
      chk("cyc_q", q, m_q);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic [31:0] f, input int sh,
                      input bit dr, input int md);
    data_i   = d;
    fill_i   = f;
    shift_i  = 6'(sh);
    dir_i    = dr;
    mode_i   = 2'(md);
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (in_ready) begin
        tick();
        in_valid = 1'b0;
        return;
      end
    end
    chk("accept_timeout", 32'(0), 32'(1));
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int lat);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    if (!out_valid) chk("result_timeout", 32'(0), 32'(1));
  endtask

  // Send, wait, check result and latency, then consume.
  task automatic run_one(input string name, input logic [31:0] d, input logic [31:0] f,
                         input int sh, input bit dr, input int md,
                         input logic [31:0] exp_q, input int exp_lat);
    int lat;
    send(d, f, sh, dr, md);
    wait_result(lat);
    chk({name, "_q"}, q, exp_q);
    chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    out_ready = 1'b1;
    tick();
    chk({name, "_drop"}, 32'(out_valid), 32'(0));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int lat2;
    bit holding;
    bit acc;

    clr = 1'b0; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dir_i = 1'b0; mode_i = 2'd0; shift_i = '0; data_i = '0; fill_i = '0;

    // Pin the reference model to hand-computed values.
    chk("ref_log_r", ref_shift(32'hF000_000F, 32'h0, 4, 1'b0, 0), 32'h0F00_0000);
    chk("ref_ari_r", ref_shift(32'h8000_0000, 32'h0, 20, 1'b0, 1), 32'hFFFF_F800);
    chk("ref_rot_l", ref_shift(32'h8000_0001, 32'h0, 33, 1'b1, 2), 32'h0000_0003);
    chk("ref_fill_l", ref_shift(32'h1234_5678, 32'hABCD_EF01, 8, 1'b1, 3), 32'h3456_78AB);
    chk("ref_fill_sat", ref_shift(32'h1234_5678, 32'hABCD_EF01, 40, 1'b1, 3), 32'hABCD_EF01);
    chk("ref_k_ari20", 32'(ref_k(20, 1)), 32'd3);

    #1;
    chk("rst_q", q, 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    tick(); tick();
    clr = 1'b1;
    tick();

    run_one("log_r4", 32'hF000_000F, 32'h0, 4, 1'b0, 0, 32'h0F00_0000, 1);
    run_one("ari_r20", 32'h8000_0000, 32'h0, 20, 1'b0, 1, 32'hFFFF_F800, 3);
    run_one("rot_l33", 32'h8000_0001, 32'h0, 33, 1'b1, 2, 32'h0000_0003, 1);
    run_one("rot_l32", 32'h8000_0001, 32'h0, 32, 1'b1, 2, 32'h8000_0001, 1);
    run_one("fill_l8", 32'h1234_5678, 32'hABCD_EF01, 8, 1'b1, 3, 32'h3456_78AB, 1);
    run_one("fill_l40", 32'h1234_5678, 32'hABCD_EF01, 40, 1'b1, 3, 32'hABCD_EF01, 4);
    run_one("shift0", 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 0, 32'hDEAD_BEEF, 1);
    run_one("log_sat", 32'hFFFF_FFFF, 32'h0, 63, 1'b1, 0, 32'h0, 4);
    run_one("ari_sat", 32'h8000_0001, 32'h0, 50, 1'b0, 1, 32'hFFFF_FFFF, 4);
    run_one("fill_r12", 32'h1234_5678, 32'hABCD_EF01, 12, 1'b0, 3, 32'hF011_2345, 2);

    // Consumer stalls: result and handshake state must hold.
    out_ready = 1'b0;
    send(32'h8000_0000, 32'h0, 20, 1'b0, 1);
    wait_result(lat);
    for (int i = 0; i < 5; i++) begin
      chk("stall_q", q, 32'hFFFF_F800);
      chk("stall_valid", 32'(out_valid), 32'(1));
      chk("stall_in_ready", 32'(in_ready), 32'(0));
      tick();
    end
    out_ready = 1'b1;
    tick();
    chk("stall_drop", 32'(out_valid), 32'(0));

    // Enable low for two cycles mid-shift stretches latency by two.
    send(32'h8000_0000, 32'h0, 20, 1'b0, 1);
    tick();
    en = 1'b0;
    tick(); tick();
    en = 1'b1;
    wait_result(lat2);
    chk("en_gap_lat", 32'(3 + lat2), 32'd5);
    chk("en_gap_q", q, 32'hFFFF_F800);
    tick();

    // Asynchronous reset between edges aborts the request immediately.
    send(32'hFFFF_FFFF, 32'h0, 31, 1'b0, 0);
    tick();
    #2;
    clr = 1'b0;
    #1;
    chk("arst_q", q, 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_in_ready", 32'(in_ready), 32'(1));
    tick();
    clr = 1'b1;
    tick();
    run_one("after_rst", 32'h1234_5678, 32'h0, 8, 1'b1, 0, 32'h3456_7800, 1);

    // Random traffic; the per-cycle comparison checks every output.
    holding = 1'b0;
    for (int c = 0; c < 600; c++) begin
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (!holding && $urandom_range(0, 1) == 1) begin
        data_i   = $urandom;
        fill_i   = $urandom;
        shift_i  = 6'($urandom_range(0, 63));
        dir_i    = 1'($urandom_range(0, 1));
        mode_i   = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        holding  = 1'b1;
      end
      @(negedge clk);
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        holding  = 1'b0;
        in_valid = 1'b0;
      end
    end
    in_valid  = 1'b0;
    en        = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    chk("drain_idle", 32'(busy), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
